// File: rtl/shift_div_pow2_pipe.sv
// Pipelined barrel shifter with four modes: logical right, arithmetic right, divide toward zero, logical left.
// Optional feature macro: SHIFT_DIV_POW2_PIPE_INEXACT_EN builds the inexact (lost-bits) tracking.
module shift_div_pow2_pipe #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [SW-1:0] in_sh,
   input  logic [1:0]    in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          out_inexact
);

   localparam logic [N-1:0] ONE  = N'(1);
   localparam logic [N-1:0] ALL1 = '1;

   // Handshake: an operation is taken on a rising edge with in_valid && in_ready,
   // a result is released on a rising edge with out_valid && out_ready; all stages
   // advance together whenever the output is not stalled.
   logic [N-1:0] bias_mask;
   logic [N-1:0] entry_data;

   logic          valid_q [SW];
   logic          valid_d [SW];
   logic [1:0]    mode_q  [SW];
   logic [1:0]    mode_d  [SW];
   logic [SW-1:0] sh_q    [SW];
   logic [SW-1:0] sh_d    [SW];
   logic [N-1:0]  data_q  [SW];
   logic [N-1:0]  data_d  [SW];
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
   logic          entry_loss;
   logic          loss_q  [SW];
   logic          loss_d  [SW];
`endif

   // Divide-toward-zero: bias negative operands so the floor shift truncates toward zero.
   assign bias_mask  = (ONE << in_sh) - ONE;
   assign entry_data = (in_mode == 2'b10 && in_data[N-1]) ? in_data + bias_mask : in_data;
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
   assign entry_loss = (in_mode == 2'b10) && (|(in_data & bias_mask));
`endif

   always_comb begin : stage_next
      logic          cur_v;
      logic [1:0]    cur_m;
      logic [SW-1:0] cur_sh;
      logic [N-1:0]  cur_d;
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
      logic          cur_l;
`endif
      for (int k = 0; k < SW; k++) begin
         if (k == 0) begin
            cur_v  = in_valid;
            cur_m  = in_mode;
            cur_sh = in_sh;
            cur_d  = entry_data;
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
            cur_l  = entry_loss;
`endif
         end else begin
            cur_v  = valid_q[k-1];
            cur_m  = mode_q[k-1];
            cur_sh = sh_q[k-1];
            cur_d  = data_q[k-1];
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
            cur_l  = loss_q[k-1];
`endif
         end
         valid_d[k] = cur_v;
         mode_d[k]  = cur_m;
         sh_d[k]    = cur_sh;
         data_d[k]  = cur_d;
         if (cur_sh[k]) begin
            case (cur_m)
               2'b00:   data_d[k] = cur_d >> (1 << k);
               2'b11:   data_d[k] = cur_d << (1 << k);
               default: data_d[k] = $signed(cur_d) >>> (1 << k);
            endcase
         end
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
         // Mode 10 loss was fully measured on the unbiased operand at entry.
         loss_d[k] = cur_l;
         if (cur_sh[k] && cur_m != 2'b10) begin
            if (cur_m == 2'b11)
               loss_d[k] = cur_l | (|(cur_d & ~(ALL1 >> (1 << k))));
            else
               loss_d[k] = cur_l | (|(cur_d & ((ONE << (1 << k)) - ONE)));
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SW; k++) begin
            valid_q[k] <= 1'b0;
            mode_q[k]  <= 2'b00;
            sh_q[k]    <= '0;
            data_q[k]  <= '0;
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
            loss_q[k]  <= 1'b0;
`endif
         end
      end else if (in_ready) begin
         for (int k = 0; k < SW; k++) begin
            valid_q[k] <= valid_d[k];
            mode_q[k]  <= mode_d[k];
            sh_q[k]    <= sh_d[k];
            data_q[k]  <= data_d[k];
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
            loss_q[k]  <= loss_d[k];
`endif
         end
      end
   end

   assign out_valid = valid_q[SW-1];
   assign out_data  = data_q[SW-1];
   assign in_ready  = !(out_valid && !out_ready);
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
   assign out_inexact = loss_q[SW-1];
`else
   assign out_inexact = 1'b0;
`endif

endmodule

// File: tb/tb_shift_div_pow2_pipe.sv
// Self-checking bench for shift_div_pow2_pipe (N=8): directed vectors, backpressure, reset, random.
module tb_shift_div_pow2_pipe;

   localparam int N  = 8;
   localparam int SW = $clog2(N);
`ifdef SHIFT_DIV_POW2_PIPE_INEXACT_EN
   localparam bit IX_EN = 1'b1;
`else
   localparam bit IX_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_data = '0;
   logic [SW-1:0] in_sh = '0;
   logic [1:0]    in_mode = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N-1:0]  out_data;
   logic          out_inexact;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [N:0] exp_q[$];
   logic       prev_stall = 1'b0;
   logic [N:0] prev_out = '0;

   shift_div_pow2_pipe #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sh      (in_sh),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_inexact(out_inexact)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ix(input logic b);
      return b & IX_EN;
   endfunction

   // Reference: plain integer arithmetic; SV integer division truncates toward zero.
   function automatic logic [N:0] model(input logic [N-1:0] d, input logic [SW-1:0] sh,
                                        input logic [1:0] m);
      int         sd;
      int         ud;
      int         lo;
      logic [N-1:0] r;
      logic       lost;
      sd   = $signed(d);
      ud   = d;
      lo   = (1 << sh) - 1;
      lost = (ud & lo) != 0;
      case (m)
         2'b00:   r = N'(ud >> sh);
         2'b01:   r = N'(sd >>> sh);
         2'b10:   r = N'(sd / (1 << sh));
         default: begin
            r    = N'(ud << sh);
            lost = ((ud << sh) >> N) != 0;
         end
      endcase
      return {ix(lost), r};
   endfunction

   // driver: call just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [N-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m,
                       input logic [N:0] exp);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_sh    = sh;
      in_mode  = m;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready && !rst;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = N'($urandom);
      in_sh    = SW'($urandom);
      in_mode  = 2'($urandom);
      if (acc) exp_q.push_back(exp);
      else check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_empty", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_latency(input string tag);
      @(negedge clk);
      check({tag, "_c1"}, out_valid, 1'b0);
      @(negedge clk);
      check({tag, "_c2"}, out_valid, 1'b0);
      @(negedge clk);
      check({tag, "_c3"}, out_valid, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_stall) check("stall_hold", {out_inexact, out_data}, prev_out);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
            else check("result", {out_inexact, out_data}, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_inexact, out_data};
      end
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_inexact", out_inexact, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // mode 01 with latency check
      send(8'h96, 3'd3, 2'b01, {ix(1'b1), 8'hF2});
      check_latency("lat_first");
      drain();

      // directed vectors back to back
      send(8'h96, 3'd3, 2'b10, {ix(1'b1), 8'hF3});
      send(8'h80, 3'd7, 2'b10, {ix(1'b0), 8'hFF});
      send(8'h7F, 3'd7, 2'b10, {ix(1'b1), 8'h00});
      send(8'hFF, 3'd0, 2'b10, {ix(1'b0), 8'hFF});
      send(8'h96, 3'd3, 2'b00, {ix(1'b1), 8'h12});
      send(8'h96, 3'd1, 2'b11, {ix(1'b1), 8'h2C});
      send(8'h16, 3'd2, 2'b11, {ix(1'b0), 8'h58});
      send(8'hA5, 3'd0, 2'b11, {ix(1'b0), 8'hA5});
      send(8'h81, 3'd7, 2'b01, {ix(1'b1), 8'hFF});
      send(8'h81, 3'd7, 2'b00, {ix(1'b1), 8'h01});
      drain();

      // backpressure: 6 back-to-back ops, out_ready low for 4 cycles mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [N-1:0]  d;
               logic [SW-1:0] sh;
               logic [1:0]    m;
               d  = N'(8'h81 + i * 37);
               sh = SW'(i + 1);
               m  = 2'(i);
               send(d, sh, m, model(d, sh, m));
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 1'b0);
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // reset with two operations in flight
      send(8'h40, 3'd2, 2'b00, {ix(1'b0), 8'h10});
      send(8'h33, 3'd1, 2'b11, {ix(1'b0), 8'h66});
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, 8'h00);
      repeat (5) @(posedge clk);
      #1;
      send(8'hC8, 3'd2, 2'b10, {ix(1'b0), 8'hF2});
      check_latency("lat_after_rst");
      drain();

      // random stream with random backpressure
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [N-1:0]  d;
               logic [SW-1:0] sh;
               logic [1:0]    m;
               d  = N'($urandom);
               sh = SW'($urandom_range(0, N - 1));
               m  = 2'($urandom_range(0, 3));
               send(d, sh, m, model(d, sh, m));
            end
         end
         begin
            repeat (90) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
